// File: rtl/lsu_subword_ctrl_if.sv
// Request/response channels between the execute stage and lsu_subword_ctrl.
// The master modport is the execute stage; the slave modport is the load/store unit.
interface lsu_subword_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_subword_ctrl.sv
// RV32 load/store unit in front of a word-addressed memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of force-aligning them.
module lsu_subword_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   lsu_subword_ctrl_if.slave bus,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_r;
   logic              we_r;
   logic [2:0]        funct3_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic              req_ready_r;
   logic              resp_valid_r;
   logic              resp_err_r;
   logic [31:0]       resp_rdata_r;
   logic [31:0]       mem_wdata_r;
   logic              acc_err_s;
   logic [ADDR_W-1:0] acc_addr_s;

   function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
      logic bad;
      case (f3)
         3'b000, 3'b001, 3'b010: bad = 1'b0;
         3'b100, 3'b101:         bad = we;
         default:                bad = 1'b1;
      endcase
      return bad;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = lo[0];
         2'b10:   mis = |lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction
`endif

   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane, input logic [31:0] data);
      logic [31:0] res;
      res = word;
      case (f3)
         3'b000:  res[{lane, 3'b000} +: 8]     = data[7:0];
         3'b001:  res[{lane[1], 4'b0000} +: 16] = data[15:0];
         default: res = data;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  res = {{24{b[7]}}, b};
         3'b001:  res = {{16{h[15]}}, h};
         3'b100:  res = {24'h000000, b};
         3'b101:  res = {16'h0000, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Request decode: error detection and effective address for the incoming request
   always_comb begin
      acc_err_s  = illegal_f3(bus.req_we, bus.req_funct3);
      acc_addr_s = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
      acc_err_s  = acc_err_s | misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
      case (bus.req_funct3[1:0])
         2'b01:   acc_addr_s[0]   = 1'b0;
         2'b10:   acc_addr_s[1:0] = 2'b00;
         default: acc_addr_s      = bus.req_addr;
      endcase
`endif
   end

   // Control FSM with all response and memory data outputs registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         we_r         <= 1'b0;
         funct3_r     <= 3'b000;
         addr_r       <= '0;
         wdata_r      <= 32'h0000_0000;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         mem_wdata_r  <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid && req_ready_r) begin
                  we_r        <= bus.req_we;
                  funct3_r    <= bus.req_funct3;
                  addr_r      <= acc_addr_s;
                  wdata_r     <= bus.req_wdata;
                  req_ready_r <= 1'b0;
                  if (acc_err_s) begin
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_rdata_r <= 32'h0000_0000;
                  end else if (!bus.req_we || bus.req_funct3 != 3'b010) begin
                     state_r <= READ;
                  end else begin
                     state_r     <= WRITE;
                     mem_wdata_r <= bus.req_wdata;
                  end
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            READ: begin
               // mem_rdata is the captured word for both the merge and the load lane select
               if (we_r) begin
                  state_r     <= WRITE;
                  mem_wdata_r <= merge_store(mem_rdata, funct3_r, addr_r[1:0], wdata_r);
               end else begin
                  state_r      <= RESP;
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= 1'b0;
                  resp_rdata_r <= load_extend(mem_rdata, funct3_r, addr_r[1:0]);
               end
            end
            WRITE: begin
               state_r      <= RESP;
               resp_valid_r <= 1'b1;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state_r      <= IDLE;
                  resp_valid_r <= 1'b0;
                  resp_err_r   <= 1'b0;
                  resp_rdata_r <= 32'h0000_0000;
                  req_ready_r  <= 1'b1;
               end else begin
                  resp_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b0;
            end
         endcase
      end
   end

   // Memory strobes decode straight from state so they vanish the moment reset asserts
   assign mem_read       = (state_r == READ);
   assign mem_write      = (state_r == WRITE);
   assign mem_addr       = addr_r[ADDR_W-1:2];
   assign mem_wdata      = mem_wdata_r;
   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_err   = resp_err_r;
   assign bus.resp_rdata = resp_rdata_r;

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
- Load/store unit sitting directly upstream of the word-addressed data memory. The data memory has a combinational read and a write on the clock edge.
- Accepts byte-addressed RV32 load/store requests from the execute stage over a valid/ready handshake.
- Word stores: issued as one direct write.
- Byte and halfword stores: issued as read-modify-write.
- Loads: returns sign- or zero-extended data over a valid/ready response channel.

Parameters:
- ADDR_W, 8, byte-address width; word address is ADDR_W-2 bits (64 words at default).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or misaligned access
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  merged write word
- mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (rst=0, async): state=IDLE; all latched request fields=0; resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; req_ready=0 while rst=0.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we, funct3, addr, wdata.
  - Next state: illegal/misaligned -> RESP with err=1; load or B/H store -> READ; W store -> WRITE.
- Illegal funct3:
  - loads: 011, 110, 111;
  - stores: anything other than 000/001/010.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- READ: mem_read=1, mem_addr=addr[ADDR_W-1:2]; mem_rdata captured into rd_q at the edge. Next: load -> RESP; store -> WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - W: mem_wdata=wdata.
  - B: rd_q with byte lane addr[1:0] replaced by wdata[7:0].
  - H: rd_q with halfword lane addr[1] replaced by wdata[15:0].
  - Next: RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1; then IDLE.
  - Lane select for loads is from rd_q by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Latency from accept edge to first resp_valid cycle:
  - load: 2;
  - W store: 2;
  - B/H store: 3;
  - error: 1.
- No request accepted while not IDLE; no pipelining (one outstanding).
- mem_read and mem_write are never both 1.
- mem_read and mem_write are decoded from state, so they drop immediately on async reset.
- Reset mid-operation: transaction aborted. Any write not yet in WRITE state is never issued. No response produced.
- resp_ready held high in IDLE has no effect.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses produce resp_err=1 with no memory access, as above.
- Undefined: misalignment is never an error. Address low bits are forced to natural alignment (H clears addr[0], W clears addr[1:0]) and the access proceeds normally.
- Illegal funct3 is an error in both builds.

Test Plan:
- Word 1 preloaded 0x80000009; LW addr 0x04 -> mem_read high exactly 1 cycle, resp_valid 2 cycles after accept, resp_rdata=0x80000009, resp_err=0.
- Same word:
  - LB 0x07 -> 0xFFFFFF80;
  - LBU 0x07 -> 0x00000080;
  - LH 0x06 -> 0xFFFF8000;
  - LHU 0x06 -> 0x00008000.
- Word 2=0x00000019; SB addr 0x09 wdata 0x123456AB -> one READ then one mem_write with mem_wdata=0x0000AB19, resp at +3, resp_rdata=0.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x06 -> resp_err=1 at +1, no mem_read/mem_write. Without the macro, same request reads word 1, returns 0x80000009, err=0.
- resp_ready held 0 for 4 cycles after a load -> resp_valid, resp_rdata stable, req_ready=0. A second request presented during this time is not accepted until 1 cycle after the handshake.
- SH addr 0x0A wdata 0xBEEF; rst pulsed low during READ -> mem_write never asserted, word 2 unchanged, resp_valid=0, FSM in IDLE after release.
